// File: rtl/fifo_pkg.sv
// Shared defaults for the parameterised FIFO: address/data widths and the
// pointer and occupancy-count widths derived from them.
package fifo_pkg;

  localparam int unsigned DefaultAw   = 3;
  localparam int unsigned DefaultDw   = 8;
  localparam int unsigned DefaultPtrW = DefaultAw;
  // One extra bit so the count can represent a completely full FIFO.
  localparam int unsigned DefaultCntW = DefaultAw + 1;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write, combinational read, contents never reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned AW = DefaultPtrW,
  parameter int unsigned DW = DefaultDw
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned AW = DefaultAw,
  parameter int unsigned DW = DefaultDw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] data_in,
  input  logic [AW:0]   umbral_almost_full,
  input  logic [AW:0]   umbral_almost_empty,
  input  logic          err_clr,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          err_overflow,
  output logic          err_underflow
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_err_ovf;
  logic          r_err_udf;

  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_overflow;
  logic          w_underflow;
  logic [AW:0]   w_count_nxt;
  logic [DW-1:0] w_rd_data;

  // Count never exceeds 2**AW, so the MSB alone marks the full state.
  assign fifo_full  = r_count[AW];
  assign fifo_empty = (r_count == '0);

  // A push into a full FIFO still lands when a pop frees the head slot on the same edge.
  assign w_pop_ok    = pop & ~fifo_empty;
  assign w_push_ok   = push & (~fifo_full | pop);
  assign w_overflow  = push & fifo_full & ~pop;
  assign w_underflow = pop & fifo_empty;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + (AW + 1)'(1);
      2'b01:   w_count_nxt = r_count - (AW + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count   <= w_count_nxt;
      // A fresh error on the clearing edge takes priority over the clear.
      r_err_ovf <= w_overflow | (r_err_ovf & ~err_clr);
      r_err_udf <= w_underflow | (r_err_udf & ~err_clr);
    end
  end

  fifo_mem #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (w_push_ok),
    .wr_addr(r_wr_ptr),
    .wr_data(data_in),
    .rd_addr(r_rd_ptr),
    .rd_data(w_rd_data)
  );

`ifdef FIFO_FWFT_EN
  // Masked when empty so stale, never-reset storage is not presented.
  assign data_out  = fifo_empty ? '0 : w_rd_data;
  assign valid_out = ~fifo_empty;
`else
  logic [DW-1:0] r_data_out;
  logic          r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_data_out <= w_rd_data;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid;
`endif

  assign count         = r_count;
  assign almost_full   = (r_count >= umbral_almost_full);
  assign almost_empty  = (r_count <= umbral_almost_empty);
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_udf;

endmodule
